// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: time-multiplexed hex seven-segment driver with
// double-buffered value/blank mask that only swaps at frame boundaries.
// Optional feature: define SEG7_LEADING_ZERO_BLANK_EN to dark leading-zero digits.
module seg7_scan_driver #(
    parameter int unsigned DIGITS      = 4,
    parameter int unsigned REFRESH_DIV = 1000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     blank_mask,
    output logic [6:0]            seg,
    output logic [DIGITS-1:0]     an,
    output logic                  pending,
    output logic                  frame_tick
);

    localparam int unsigned PCNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int unsigned IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int unsigned VAL_W  = 4 * DIGITS;

    localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DIGITS - 1);

    logic [PCNT_W-1:0] pcnt_q, pcnt_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [VAL_W-1:0]  stg_val_q, stg_val_d;
    logic [DIGITS-1:0] stg_mask_q, stg_mask_d;
    logic [VAL_W-1:0]  shd_val_q, shd_val_d;
    logic [DIGITS-1:0] shd_mask_q, shd_mask_d;
    logic              pending_q, pending_d;
    logic [6:0]        seg_q, seg_d;
    logic [DIGITS-1:0] an_q, an_d;
    logic              tick_q, tick_d;

    logic              tc;
    logic              frame_bnd;
    logic [3:0]        cur_nib;
    logic              cur_mask;
    logic              lz_blank;

    // Hex nibble to {a,b,c,d,e,f,g}, active-high
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0:    s = 7'h7E;
            4'h1:    s = 7'h30;
            4'h2:    s = 7'h6D;
            4'h3:    s = 7'h79;
            4'h4:    s = 7'h33;
            4'h5:    s = 7'h5B;
            4'h6:    s = 7'h5F;
            4'h7:    s = 7'h70;
            4'h8:    s = 7'h7F;
            4'h9:    s = 7'h7B;
            4'hA:    s = 7'h77;
            4'hB:    s = 7'h1F;
            4'hC:    s = 7'h4E;
            4'hD:    s = 7'h3D;
            4'hE:    s = 7'h4F;
            default: s = 7'h47;
        endcase
        return s;
    endfunction

    // Prescaler and digit index advance; frame boundary detection
    always_comb begin
        tc        = (pcnt_q == PCNT_LAST);
        frame_bnd = tc && (idx_q == IDX_LAST);
        pcnt_d    = tc ? '0 : pcnt_q + PCNT_W'(1);
        idx_d     = idx_q;
        if (tc) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
        end
        // Registered pulse lands in the cycle that will be the boundary
        tick_d = (pcnt_d == PCNT_LAST) && (idx_d == IDX_LAST);
    end

    // Staging/shadow double buffer; a load coinciding with the boundary bypasses staging
    always_comb begin
        stg_val_d  = stg_val_q;
        stg_mask_d = stg_mask_q;
        shd_val_d  = shd_val_q;
        shd_mask_d = shd_mask_q;
        pending_d  = pending_q;
        if (load) begin
            stg_val_d  = value;
            stg_mask_d = blank_mask;
        end
        if (frame_bnd) begin
            pending_d = 1'b0;
            if (load) begin
                shd_val_d  = value;
                shd_mask_d = blank_mask;
            end else if (pending_q) begin
                shd_val_d  = stg_val_q;
                shd_mask_d = stg_mask_q;
            end
        end else if (load) begin
            pending_d = 1'b1;
        end
    end

    // Select current digit from shadow, apply blanking and decode
    always_comb begin
        cur_nib  = 4'h0;
        cur_mask = 1'b0;
        an_d     = '0;
        lz_blank = 1'b0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (idx_q == IDX_W'(i)) begin
                cur_nib  = shd_val_q[4*i +: 4];
                cur_mask = shd_mask_q[i];
                an_d[i]  = 1'b1;
            end
        end
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        begin : g_lz
            logic zero_above;
            zero_above = 1'b1;
            // Walk down from the top digit; digit 0 is never zero-blanked
            for (int i = int'(DIGITS) - 1; i >= 1; i--) begin
                zero_above = zero_above && (shd_val_q[4*i +: 4] == 4'h0);
                if ((idx_q == IDX_W'(i)) && zero_above) begin
                    lz_blank = 1'b1;
                end
            end
        end
`else
        lz_blank = 1'b0;
`endif
        seg_d = (cur_mask || lz_blank) ? 7'h00 : hex_to_seg(cur_nib);
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            pcnt_q     <= '0;
            idx_q      <= '0;
            stg_val_q  <= '0;
            stg_mask_q <= '0;
            shd_val_q  <= '0;
            shd_mask_q <= '0;
            pending_q  <= 1'b0;
            seg_q      <= '0;
            an_q       <= '0;
            tick_q     <= 1'b0;
        end else begin
            pcnt_q     <= pcnt_d;
            idx_q      <= idx_d;
            stg_val_q  <= stg_val_d;
            stg_mask_q <= stg_mask_d;
            shd_val_q  <= shd_val_d;
            shd_mask_q <= shd_mask_d;
            pending_q  <= pending_d;
            seg_q      <= seg_d;
            an_q       <= an_d;
            tick_q     <= tick_d;
        end
    end

    assign seg        = seg_q;
    assign an         = an_q;
    assign pending    = pending_q;
    assign frame_tick = tick_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver (DIGITS=4, REFRESH_DIV=4).
// Reference: frame position from cycle arithmetic plus the load/boundary buffer rules.
module tb_seg7_scan_driver;

    localparam int unsigned DIGITS = 4;
    localparam int unsigned RD     = 4;
    localparam int unsigned F      = DIGITS * RD;

    logic        clk;
    logic        rst;
    logic        load;
    logic [15:0] value;
    logic [3:0]  blank_mask;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        pending;
    logic        frame_tick;

    int n_cmp = 0;
    int n_err = 0;

    // Reference state
    logic [15:0] m_st, m_sh;
    logic [3:0]  m_stm, m_shm;
    bit          m_pend;
    int unsigned cyc;
    logic [6:0]  tbl [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                              7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

    seg7_scan_driver #(.DIGITS(DIGITS), .REFRESH_DIV(RD)) dut (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .value      (value),
        .blank_mask (blank_mask),
        .seg        (seg),
        .an         (an),
        .pending    (pending),
        .frame_tick (frame_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [6:0] ref_seg(input logic [15:0] sv, input logic [3:0] sm, input int d);
        logic [3:0] nib;
        bit         blank;
        nib   = sv[4*d +: 4];
        blank = sm[d];
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        if (d > 0 && (sv >> (4*d)) == 16'h0) blank = 1'b1;
`endif
        return blank ? 7'h00 : tbl[nib];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // One clock: drive inputs, advance the reference, compare all outputs at negedge
    task automatic step(input logic l, input logic [15:0] v, input logic [3:0] m, input logic r);
        logic [6:0] e_seg;
        logic [3:0] e_an;
        bit         e_tick;
        int         pos, d;
        rst = r; load = l; value = v; blank_mask = m;
        if (r) begin
            e_seg = '0; e_an = '0; e_tick = 1'b0;
            m_st = '0; m_stm = '0; m_sh = '0; m_shm = '0; m_pend = 1'b0; cyc = 0;
        end else begin
            pos   = int'(cyc % F);
            d     = pos / int'(RD);
            e_an  = 4'(1 << d);
            e_seg = ref_seg(m_sh, m_shm, d);
            if (pos == int'(F) - 1) begin
                if (l) begin
                    m_sh = v; m_shm = m; m_st = v; m_stm = m;
                end else if (m_pend) begin
                    m_sh = m_st; m_shm = m_stm;
                end
                m_pend = 1'b0;
            end else if (l) begin
                m_st = v; m_stm = m; m_pend = 1'b1;
            end
            cyc++;
            e_tick = ((cyc % F) == F - 1);
        end
        @(posedge clk);
        @(negedge clk);
        check("seg", 32'(seg), 32'(e_seg));
        check("an", 32'(an), 32'(e_an));
        check("pending", 32'(pending), 32'(m_pend));
        check("frame_tick", 32'(frame_tick), 32'(e_tick));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 16'h0, 4'h0, 1'b0);
    endtask

    // Advance until the next cycle to execute is a frame boundary (at most F-1 steps)
    task automatic to_tick();
        for (int i = 0; i < int'(F) && (cyc % F) != F - 1; i++) step(1'b0, 16'h0, 4'h0, 1'b0);
    endtask

    task automatic cross_boundary();
        to_tick();
        step(1'b0, 16'h0, 4'h0, 1'b0);
    endtask

    initial begin
        logic [15:0] sweep [4];
        sweep[0] = 16'h3210; sweep[1] = 16'h7654; sweep[2] = 16'hBA98; sweep[3] = 16'hFEDC;
        rst = 1'b1; load = 1'b0; value = '0; blank_mask = '0;
        m_st = '0; m_stm = '0; m_sh = '0; m_shm = '0; m_pend = 1'b0; cyc = 0;

        // Reset held 3 cycles; load during reset is ignored
        step(1'b0, 16'h0, 4'h0, 1'b1);
        step(1'b1, 16'hFFFF, 4'hF, 1'b1);
        step(1'b0, 16'h0, 4'h0, 1'b1);
        idle(1);
        check("first_an", 32'(an), 32'h1);
        check("first_seg", 32'(seg), 32'h7E);
        idle(2 * int'(F));

        // Decode sweep
        for (int k = 0; k < 4; k++) begin
            cross_boundary();
            step(1'b1, sweep[k], 4'h0, 1'b0);
        end
        cross_boundary();
        idle(int'(F));

        // Double buffering
        idle(5);
        step(1'b1, 16'h1234, 4'h0, 1'b0);
        check("pend_imm", 32'(pending), 32'h1);
        cross_boundary();
        check("pend_clear", 32'(pending), 32'h0);
        idle(1);
        check("dbuf_an", 32'(an), 32'h1);
        check("dbuf_seg4", 32'(seg), 32'h33);

        // Last load wins, then load on the frame_tick cycle
        idle(2);
        step(1'b1, 16'hAAAA, 4'h0, 1'b0);
        idle(3);
        step(1'b1, 16'h5555, 4'h0, 1'b0);
        cross_boundary();
        idle(1);
        check("lastwin_seg", 32'(seg), 32'h5B);
        idle(int'(F));
        to_tick();
        check("tick_at_load", 32'(frame_tick), 32'h1);
        step(1'b1, 16'h0F0F, 4'h0, 1'b0);
        check("coll_pend", 32'(pending), 32'h0);
        idle(1);
        check("coll_seg", 32'(seg), 32'h47);
        idle(int'(F));

        // Blanking
        cross_boundary();
        step(1'b1, 16'h0042, 4'h1, 1'b0);
        cross_boundary();
        idle(1);
        check("blank_d0", 32'(seg), 32'h0);
        idle(int'(RD));
        check("blank_d1", 32'(seg), 32'h33);
        idle(int'(RD));
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        check("blank_d2", 32'(seg), 32'h00);
        idle(int'(RD));
        check("blank_d3", 32'(seg), 32'h00);
`else
        check("blank_d2", 32'(seg), 32'h7E);
        idle(int'(RD));
        check("blank_d3", 32'(seg), 32'h7E);
`endif
        idle(int'(F));

        // Reset mid-frame with a pending load
        cross_boundary();
        step(1'b1, 16'h1234, 4'h0, 1'b0);
        cross_boundary();
        idle(5);
        step(1'b1, 16'h9999, 4'h0, 1'b0);
        step(1'b0, 16'h0, 4'h0, 1'b1);
        check("rst_pend", 32'(pending), 32'h0);
        check("rst_an", 32'(an), 32'h0);
        idle(1);
        check("rst_restart_an", 32'(an), 32'h1);
        check("rst_restart_seg", 32'(seg), 32'h7E);
        idle(2 * int'(F));

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            logic        r, l;
            logic [15:0] v;
            logic [3:0]  m;
            r = ($urandom_range(0, 99) == 0);
            l = ($urandom_range(0, 7) == 0);
            v = 16'($urandom);
            m = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
            step(l, v, m, r);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
